// File: rtl/cam_emu_pkg.sv
// cam_emu_pkg: shared state encoding, RGB565 field widths and colour-bar table
// for camera_emulator.
package cam_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } cam_state_e;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [PIX_W-1:0] BAR_COLOURS [0:7] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/cam_emu_pclk.sv
// cam_pclk_gen: divides clk into cam_pclk and flags the clk cycles on which
// cam_pclk is about to rise or fall.
module cam_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_pclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam logic [7:0] DIV_LAST = 8'(PCLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_pclk;
  logic       w_toggle;

  assign w_toggle    = i_run && (r_div_cnt == DIV_LAST);
  assign o_rise_tick = w_toggle && !r_pclk;
  assign o_fall_tick = w_toggle && r_pclk;
  assign o_pclk      = r_pclk;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_pclk    <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_pclk    <= 1'b0;
    end else if (w_toggle) begin
      r_div_cnt <= '0;
      r_pclk    <= !r_pclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/camera_emulator.sv
// camera_emulator: replays a frame buffer as an OV7670-style RGB565 camera bus.
// Define CAM_EMU_TEST_PATTERN_EN to add test_mode and an internal colour-bar source.
module camera_emulator
  import cam_emu_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int PCLK_DIV = 2,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
`ifdef CAM_EMU_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              cam_pclk,
  output logic              cam_href,
  output logic              cam_vsync,
  output logic [7:0]        cam_data,
  output logic              frame_done
);

  localparam int          LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST   = 16'(LINE_LEN - 1);
  localparam logic [15:0] H_HREF   = 16'(2 * H_ACTIVE);
  localparam logic [15:0] VS_LAST  = 16'(V_SYNC - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);

  cam_state_e        r_state, w_next_state, w_succ_state;
  logic [15:0]       r_h_cnt, r_v_cnt, w_succ_h, w_succ_v, w_v_last;
  logic              w_line_end, w_sect_end, w_succ_href;
  logic              w_run, w_pclk, w_rise_tick, w_fall_tick;
  logic              w_rd_req, w_pattern_on, r_rd_pend;
  logic [PIX_W-1:0]  r_pix, w_pix;
  logic [ADDR_W-1:0] r_addr;
  logic              r_href, r_vsync, r_frame_done;
  logic [7:0]        r_data;

  // Keep the divider running until an in-flight pclk high phase has ended.
  assign w_run = (r_state != IDLE) || enable || w_pclk;

  cam_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (w_run),
    .o_pclk      (w_pclk),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_v_last = 16'd0;
    unique case (r_state)
      VSYNC:   w_v_last = VS_LAST;
      VBACK:   w_v_last = VB_LAST;
      ACTIVE:  w_v_last = VA_LAST;
      VFRONT:  w_v_last = VF_LAST;
      default: w_v_last = 16'd0;
    endcase
  end

  assign w_line_end = (r_h_cnt == H_LAST);
  assign w_sect_end = w_line_end && (r_v_cnt == w_v_last);

  // r_state/r_h_cnt/r_v_cnt describe the pclk period now on the bus; the
  // successor is the period that the next fall tick will put on the bus.
  always_comb begin
    w_succ_state = r_state;
    w_succ_h     = w_line_end ? 16'd0 : r_h_cnt + 16'd1;
    w_succ_v     = w_sect_end ? 16'd0 : (w_line_end ? r_v_cnt + 16'd1 : r_v_cnt);
    unique case (r_state)
      IDLE: begin
        w_succ_state = enable ? VSYNC : IDLE;
        w_succ_h     = 16'd0;
        w_succ_v     = 16'd0;
      end
      VSYNC:   if (w_sect_end) w_succ_state = VBACK;
      VBACK:   if (w_sect_end) w_succ_state = ACTIVE;
      ACTIVE:  if (w_sect_end) w_succ_state = VFRONT;
      VFRONT:  if (w_sect_end) w_succ_state = enable ? VSYNC : IDLE;
      default: w_succ_state = IDLE;
    endcase
    w_next_state = w_fall_tick ? w_succ_state : r_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= 16'd0;
    end else if (w_fall_tick) begin
      r_h_cnt <= w_succ_h;
      r_v_cnt <= w_succ_v;
    end
  end

  assign w_succ_href = (w_succ_state == ACTIVE) && (w_succ_h < H_HREF);

`ifdef CAM_EMU_TEST_PATTERN_EN
  logic [15:0] w_x;
  logic [2:0]  w_bar;
  assign w_pattern_on = test_mode;
  assign w_x          = {1'b0, w_succ_h[15:1]};
  assign w_bar        = 3'((int'(w_x) * 8) / H_ACTIVE);
  assign w_pix        = test_mode ? bar_colour(w_bar) : r_pix;
`else
  assign w_pattern_on = 1'b0;
  assign w_pix        = r_pix;
`endif

  // Fetch on the rise tick just before the fall tick that shows the pixel's high byte.
  assign w_rd_req = w_rise_tick && w_succ_href && !w_succ_h[0] && !w_pattern_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend    <= 1'b0;
      r_pix        <= '0;
      r_addr       <= '0;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_data       <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_req;
      if (r_rd_pend) r_pix <= fb_rd_data;
      if (w_fall_tick && (w_succ_state == VSYNC) && (r_state != VSYNC)) begin
        r_addr <= '0;
      end else if (w_rd_req) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      r_frame_done <= w_fall_tick && (w_succ_state == ACTIVE) &&
                      (w_succ_v == VA_LAST) && (w_succ_h == H_HREF);
      if (w_fall_tick) begin
        r_vsync <= (w_succ_state == VSYNC);
        r_href  <= w_succ_href;
        r_data  <= w_succ_href ? (w_succ_h[0] ? w_pix[7:0] : w_pix[15:8]) : 8'd0;
      end
    end
  end

  assign fb_rd_en   = w_rd_req;
  assign fb_rd_addr = r_addr;
  assign cam_pclk   = w_pclk;
  assign cam_href   = r_href;
  assign cam_vsync  = r_vsync;
  assign cam_data   = r_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_camera_emulator.sv
// tb_camera_emulator: directed bench for camera_emulator using a reduced frame
// geometry so several complete frames fit in a short run.
module tb_camera_emulator;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int H_BLANK  = 4;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 2;
  localparam int V_FRONT  = 2;
  localparam int PCLK_DIV = 2;
  localparam int ADDR_W   = 17;

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;                       // 20 periods
  localparam int FRAME_PER = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * LINE_LEN; // 200
  localparam int NPIX      = H_ACTIVE * V_ACTIVE;                           // 32
  localparam int FIRST_ACT = V_SYNC + V_BACK;                               // line 4
  localparam int FD_AT     = (FIRST_ACT + V_ACTIVE - 1) * LINE_LEN + 2 * H_ACTIVE; // 156

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [15:0]       fb_rd_data = 16'h0000;
  logic              cam_pclk, cam_href, cam_vsync, frame_done;
  logic [7:0]        cam_data;

  int n_checks = 0;
  int n_errors = 0;

  logic        mon_on = 1'b0;
  logic        prev_pclk = 1'b0;
  logic [9:0]  q_per[$];
  logic [16:0] q_rd[$];
  int          q_rd_at[$];
  int          q_fd[$];

  always #5 clk = ~clk;

  camera_emulator #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .PCLK_DIV(PCLK_DIV), .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
`ifdef CAM_EMU_TEST_PATTERN_EN
    .test_mode  (1'b0),
`endif
    .cam_pclk   (cam_pclk),
    .cam_href   (cam_href),
    .cam_vsync  (cam_vsync),
    .cam_data   (cam_data),
    .frame_done (frame_done)
  );

  // Frame memory contents: distinct high and low bytes for every address.
  function automatic logic [15:0] pix_of(input int a);
    return 16'(a * 259 + 16'h4000);
  endfunction

  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= pix_of(int'(fb_rd_addr));
  end

  // Receiver view: one entry per cam_pclk rise, plus read and frame_done events.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cam_pclk && !prev_pclk) q_per.push_back({cam_vsync, cam_href, cam_data});
      if (fb_rd_en) begin
        q_rd.push_back(fb_rd_addr);
        q_rd_at.push_back(q_per.size());
      end
      if (frame_done) q_fd.push_back(q_per.size());
    end
    prev_pclk <= cam_pclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_per.delete();
    q_rd.delete();
    q_rd_at.delete();
    q_fd.delete();
  endtask

  // Called at a negedge with pclk low: waits for the first rise and first fall.
  task automatic start_frame(input string tag);
    int n = 0;
    while (!cam_pclk && n < 40) begin @(negedge clk); n++; end
    check({tag, "_rise_clks"}, n, PCLK_DIV);
    check({tag, "_pre_vsync"}, cam_vsync, 1'b0);
    while (cam_pclk && n < 40) begin @(negedge clk); n++; end
    check({tag, "_first_fall_vsync"}, {cam_pclk, cam_vsync}, 2'b01);
    clear_mon();
    mon_on = 1'b1;
  endtask

  task automatic wait_periods(input int cnt);
    for (int i = 0; i < 4000 && q_per.size() < cnt; i++) @(posedge clk);
  endtask

  task automatic analyze_frame(input string tag);
    int vs_err = 0, hr_err = 0, d_err = 0, rd_err = 0;
    int line, h, k_line, k_pix, exp_at;
    logic ev, eh;
    logic [7:0] ed;
    logic [15:0] px;
    wait_periods(FRAME_PER);
    check({tag, "_periods"}, q_per.size(), FRAME_PER);
    for (int p = 0; p < FRAME_PER && p < q_per.size(); p++) begin
      line = p / LINE_LEN;
      h    = p % LINE_LEN;
      ev   = (line < V_SYNC);
      eh   = (line >= FIRST_ACT) && (line < FIRST_ACT + V_ACTIVE) && (h < 2 * H_ACTIVE);
      px   = pix_of((line - FIRST_ACT) * H_ACTIVE + h / 2);
      ed   = eh ? ((h % 2 == 1) ? px[7:0] : px[15:8]) : 8'h00;
      if (q_per[p][9] !== ev) vs_err++;
      if (q_per[p][8] !== eh) hr_err++;
      if (q_per[p][7:0] !== ed) d_err++;
    end
    check({tag, "_vsync_errs"}, vs_err, 0);
    check({tag, "_href_errs"}, hr_err, 0);
    check({tag, "_data_errs"}, d_err, 0);
    check({tag, "_reads"}, q_rd.size(), NPIX);
    for (int k = 0; k < q_rd.size(); k++) begin
      k_line = k / H_ACTIVE;
      k_pix  = k % H_ACTIVE;
      exp_at = (FIRST_ACT + k_line) * LINE_LEN + 2 * k_pix - 1;
      if (q_rd[k] !== 17'(k) || q_rd_at[k] != exp_at) rd_err++;
    end
    check({tag, "_read_addr_timing_errs"}, rd_err, 0);
    check({tag, "_frame_done_cnt"}, q_fd.size(), 1);
    check({tag, "_frame_done_at"}, (q_fd.size() > 0) ? q_fd[0] : -1, FD_AT);
    clear_mon();
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    enable  = 1'b1;
    seen    = 1'b0;

    // Held in reset with enable high: everything low and pclk static.
    repeat (6) begin
      @(negedge clk);
      seen |= cam_pclk;
    end
    check("reset_outputs", {fb_rd_en, fb_rd_addr, cam_pclk, cam_href, cam_vsync, cam_data, frame_done}, 0);
    check("reset_pclk_static", seen, 1'b0);

    reset_n = 1'b1;
    start_frame("f1");
    analyze_frame("f1");

    // Frame 2 runs back-to-back; enable drops mid-frame and the frame still completes.
    wait_periods(100);
    @(negedge clk);
    enable = 1'b0;
    analyze_frame("f2");
    repeat (40) @(negedge clk);
    check("idle_pclk", cam_pclk, 1'b0);
    check("idle_periods", q_per.size(), 0);
    check("idle_reads", q_rd.size(), 0);

    // Frame 3 is cut by an asynchronous reset inside an href window.
    mon_on = 1'b0;
    enable = 1'b1;
    start_frame("f3");
    wait_periods(90);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    mon_on  = 1'b0;
    enable  = 1'b0;
    #1;
    check("midreset_outputs", {fb_rd_en, fb_rd_addr, cam_pclk, cam_href, cam_vsync, cam_data, frame_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= cam_pclk | cam_href | cam_vsync | fb_rd_en;
    end
    check("post_reset_idle", seen, 1'b0);

    // Restart after reset begins with a full vsync and address 0.
    enable = 1'b1;
    start_frame("f4");
    analyze_frame("f4");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/camera_emulator.md
Name: camera_emulator

Overview:
- Transmit-side counterpart of the camera capture path.
- Reads RGB565 pixels from a frame memory and drives an OV7670-style parallel bus: cam_pclk, cam_href, cam_vsync and cam_data, two bytes per pixel, high byte first.
- Used as a bench/bring-up source for the capture path and framebuffer when no sensor is attached.
- Sits between a dual-port pixel RAM read port and the camera-input pins or their loopback.

Parameters:
- H_ACTIVE, 320, active pixels per line.
- V_ACTIVE, 240, active lines per frame.
- H_BLANK, 144, pclk periods with href low after each line.
- V_SYNC, 3, lines with vsync high.
- V_BACK, 17, lines after vsync fall and before the first active line.
- V_FRONT, 10, lines after the last active line and before vsync rise.
- PCLK_DIV, 2, clk cycles per pclk half-period; legal minimum 2.
- ADDR_W, 17, frame-memory address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled only at frame start
- fb_rd_en  out  1  one-clk read strobe
- fb_rd_addr  out  ADDR_W  pixel address, 0 .. H_ACTIVE*V_ACTIVE-1
- fb_rd_data  in  16  RGB565 pixel; valid the clk after fb_rd_en
- cam_pclk  out  1  generated pixel clock; receiver samples on its rising edge
- cam_href  out  1  line-valid
- cam_vsync  out  1  frame sync, active high
- cam_data  out  8  byte lane
- frame_done  out  1  one-clk pulse after the last byte of a frame

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; pixel address 0.
- pclk generation: a divider toggles cam_pclk every PCLK_DIV clks while state is not IDLE. In IDLE, cam_pclk is held 0.
- Define "fall tick" as the clk on which cam_pclk goes 1->0, and "rise tick" as the clk on which it goes 0->1.
- Output update timing: cam_href, cam_vsync and cam_data change only on fall ticks. They are therefore stable across every pclk rising edge.
- Line timing: every line is 2*H_ACTIVE + H_BLANK pclk periods.
  - On active lines, href is high for the first 2*H_ACTIVE periods and low for the remainder.
  - On all other lines, href is low.
- FSM states: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> VSYNC/IDLE.
  - IDLE: leaves when enable=1. Pixel address cleared to 0; next state VSYNC.
  - VSYNC: cam_vsync=1 for V_SYNC lines.
  - VBACK: cam_vsync=0 for V_BACK lines.
  - ACTIVE: V_ACTIVE lines, each with an href window followed by blank.
  - VFRONT: V_FRONT lines. At its end, go to VSYNC if enable=1, else IDLE.
- Byte order per pixel: byte 0 = pix[15:8], byte 1 = pix[7:0]. Each byte is held for exactly one pclk period.
- Prefetch:
  - fb_rd_en pulses for 1 clk on the rise tick immediately before the fall tick that emits a pixel's byte 0.
  - For the first pixel of a line, that rise tick falls in the last blank/previous period.
  - fb_rd_data is registered on the following clk. Hence PCLK_DIV>=2.
- Address rules:
  - Address increments by 1 after each read.
  - Reaches H_ACTIVE*V_ACTIVE-1 on the final pixel.
  - Reset to 0 on entry to VSYNC; there is no wrap inside a frame.
- frame_done: pulses on the fall tick that drops href after the last active line.
- Enable deasserted mid-frame: the current frame completes fully, then IDLE.
- reset_n asserted mid-line: outputs are immediately 0. After release, the block waits in IDLE and always restarts with a full VSYNC.
- cam_data outside the href window is 0.

Optional Feature:
- Macro: CAM_EMU_TEST_PATTERN_EN.
- When defined, an extra input port test_mode (1 bit) exists. With test_mode=1, pixel data comes from an internal 8-bar colour generator and fb_rd_en stays 0.
  - The generator outputs bar index = x*8/H_ACTIVE, mapped to RGB565 values: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
- When undefined, the port and the generator are absent, and data always comes from fb_rd_data.

Decomposition:
- Package cam_emu_pkg holds:
  - the state enum typedef (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - RGB565 field-width constants;
  - the colour-bar constant array.
- One sub-module: cam_pclk_gen. It contains the divider and produces cam_pclk plus rise_tick and fall_tick strobes. The top contains the FSM, counters and the prefetch register.

Test Plan:
- Reset check: hold reset_n=0 with enable=1 -> all outputs 0 and cam_pclk static. Release -> first cam_pclk rise after PCLK_DIV clks, and cam_vsync=1 from the first fall tick.
- Single-line byte check: fb model returns pix=addr*3 (16 bits), PCLK_DIV=2 -> the first 640 bytes sampled on pclk rises while href=1 equal {pix[15:8], pix[7:0]} for addr 0..319. Followed by exactly 144 href-low periods.
- Frame timing check: count pclk periods -> vsync high for 3*784, 17 blank lines, 240 href pulses of 640 periods each, 10 blank lines. frame_done pulses once; next frame's first read has fb_rd_addr=0.
- Read latency check: every fb_rd_en is followed by exactly one fall tick before its byte 0 appears. 76800 reads per frame and no read outside ACTIVE.
- Enable and reset mid-frame: drop enable at line 100 -> the frame completes, 76800 reads total, then IDLE with cam_pclk=0. Assert reset_n at line 50 -> outputs 0 within the same clk; after release, the block stays idle until enable and restarts from VSYNC.
- Loopback: connect to the capture block and the framebuffer, with source pixel 0xF800 -> each captured gray byte equals (31+0+0)>>1 = 15, written to addresses 0..76799 once per frame.
